// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: opcodes, default widths, held entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_REG_W  = 5;

  // Operation codes as decoded by the downstream ALU
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1001;

  // One held instruction: source indices are kept so writebacks can be
  // snooped while the entry waits on a downstream stall.
  typedef struct packed {
    logic [ALU_REG_W-1:0]  rs1;
    logic [ALU_REG_W-1:0]  rs2;
    logic                  alu_src;
    logic [ALU_OP_W-1:0]   op;
    logic [ALU_REG_W-1:0]  rd;
    logic                  we;
    logic [ALU_DATA_W-1:0] src_a;
    logic [ALU_DATA_W-1:0] src_b;
    logic [ALU_DATA_W-1:0] store_data;
  } entry_t;

endpackage

// File: rtl/fwd_mux.sv
// Priority forward select: EX/MEM over MEM/WB over register-file value; x0 never forwarded.
// Latency: combinational.
// Backpressure: none.
module fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_val,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic                  i_exmem_we,
  input  logic [DATA_WIDTH-1:0] i_exmem_result,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  input  logic                  i_memwb_we,
  input  logic [DATA_WIDTH-1:0] i_memwb_result,
  output logic [DATA_WIDTH-1:0] o_val
);

  logic w_nonzero;
  assign w_nonzero = (i_addr != '0);

  // Younger result (EX/MEM) wins when both stages target the same register
  always_comb begin
    o_val = i_rf_val;
    if (w_nonzero && i_exmem_we && (i_exmem_rd == i_addr)) begin
      o_val = i_exmem_result;
    end else if (w_nonzero && i_memwb_we && (i_memwb_rd == i_addr)) begin
      o_val = i_memwb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: forwards operands on capture and keeps snooping writebacks while held.
// Latency: 1 cycle from in_valid&&in_ready to out_valid.
// Backpressure: single entry, in_ready = !out_valid || out_ready (no skid buffer).
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = ALU_DATA_W,
  parameter int OPCODE_LENGTH = ALU_OP_W,
  parameter int REG_ADDR_W    = ALU_REG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_ADDR_W-1:0]    rs1_addr,
  input  logic [REG_ADDR_W-1:0]    rs2_addr,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic                     alu_src,
  input  logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [REG_ADDR_W-1:0]    rd_addr_in,
  input  logic                     reg_write_in,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_we,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_we,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    src_a,
  output logic [DATA_WIDTH-1:0]    src_b,
  output logic [OPCODE_LENGTH-1:0] operation,
  output logic [DATA_WIDTH-1:0]    store_data,
  output logic [REG_ADDR_W-1:0]    rd_addr_out,
  output logic                     reg_write_out
);

  entry_t r_ent;
  logic   r_vld;

  logic                  w_take;
  logic                  w_hold;
  logic [DATA_WIDTH-1:0] w_cap_a;
  logic [DATA_WIDTH-1:0] w_cap_b;
  logic [DATA_WIDTH-1:0] w_snp_a;
  logic [DATA_WIDTH-1:0] w_snp_b;

  assign in_ready = !r_vld || out_ready;
  assign w_take   = in_valid && in_ready;
  assign w_hold   = r_vld && !out_ready;

  // Capture path: forward against the register-file read values
  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_cap_rs1 (
    .i_addr(rs1_addr), .i_rf_val(rs1_data),
    .i_exmem_rd(exmem_rd), .i_exmem_we(exmem_we), .i_exmem_result(exmem_result),
    .i_memwb_rd(memwb_rd), .i_memwb_we(memwb_we), .i_memwb_result(memwb_result),
    .o_val(w_cap_a)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_cap_rs2 (
    .i_addr(rs2_addr), .i_rf_val(rs2_data),
    .i_exmem_rd(exmem_rd), .i_exmem_we(exmem_we), .i_exmem_result(exmem_result),
    .i_memwb_rd(memwb_rd), .i_memwb_we(memwb_we), .i_memwb_result(memwb_result),
    .o_val(w_cap_b)
  );

  // Snoop path: the held value stands in for the register file, so a
  // register with no matching writeback simply keeps its current value.
  // store_data always carries rs2, even when src_b holds the immediate.
  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_snp_rs1 (
    .i_addr(r_ent.rs1), .i_rf_val(r_ent.src_a),
    .i_exmem_rd(exmem_rd), .i_exmem_we(exmem_we), .i_exmem_result(exmem_result),
    .i_memwb_rd(memwb_rd), .i_memwb_we(memwb_we), .i_memwb_result(memwb_result),
    .o_val(w_snp_a)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_snp_rs2 (
    .i_addr(r_ent.rs2), .i_rf_val(r_ent.store_data),
    .i_exmem_rd(exmem_rd), .i_exmem_we(exmem_we), .i_exmem_result(exmem_result),
    .i_memwb_rd(memwb_rd), .i_memwb_we(memwb_we), .i_memwb_result(memwb_result),
    .o_val(w_snp_b)
  );

  // Entry register: reset > flush > capture > hold-snoop > drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_ent <= '0;
    end else if (flush) begin
      r_vld    <= 1'b0;
      r_ent.op <= ALU_ADD;
      r_ent.we <= 1'b0;
    end else if (w_take) begin
      r_vld            <= 1'b1;
      r_ent.rs1        <= rs1_addr;
      r_ent.rs2        <= rs2_addr;
      r_ent.alu_src    <= alu_src;
      r_ent.op         <= alu_op;
      r_ent.rd         <= rd_addr_in;
      r_ent.we         <= reg_write_in;
      r_ent.src_a      <= w_cap_a;
      r_ent.src_b      <= alu_src ? imm : w_cap_b;
      r_ent.store_data <= w_cap_b;
    end else if (w_hold) begin
      r_ent.src_a      <= w_snp_a;
      r_ent.store_data <= w_snp_b;
      if (!r_ent.alu_src) begin
        r_ent.src_b <= w_snp_b;
      end
    end else begin
      // Either empty or the held entry was consumed with nothing behind it
      r_vld <= 1'b0;
    end
  end

  assign out_valid     = r_vld;
  assign src_a         = r_ent.src_a;
  assign src_b         = r_ent.src_b;
  assign operation     = r_ent.op;
  assign store_data    = r_ent.store_data;
  assign rd_addr_out   = r_ent.rd;
  assign reg_write_out = r_ent.we;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for the ALU operand stage with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr_in;
  logic        reg_write_in;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_we, memwb_we;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src_a, src_b, store_data;
  logic [3:0]  operation;
  logic [4:0]  rd_addr_out;
  logic        reg_write_out;

  int n_vec = 0;
  int n_err = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_src(alu_src), .alu_op(alu_op),
    .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .src_a(src_a), .src_b(src_b), .operation(operation), .store_data(store_data),
    .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    exmem_rd = '0; exmem_we = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_we = 1'b0; memwb_result = '0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1;
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = 32'h55; rs2_data = 32'h66;
    imm = 32'h0; alu_src = 1'b0; alu_op = 4'h3; rd_addr_in = 5'd4; reg_write_in = 1'b1;
    no_fwd();

    // Reset held with a valid instruction presented
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_operation", {28'b0, operation}, 32'h0);
    chk("rst_src_a", src_a, 32'h0);
    chk("rst_src_b", src_b, 32'h0);
    chk("rst_store", store_data, 32'h0);
    chk("rst_rd", {27'b0, rd_addr_out}, 32'h0);
    chk("rst_we", {31'b0, reg_write_out}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Forward priority: both sources match rs1=5, EX/MEM wins
    rst_n = 1'b1;
    rs1_addr = 5'd5; rs1_data = 32'h1234; rs2_addr = 5'd6; rs2_data = 32'h66;
    alu_op = 4'h1; rd_addr_in = 5'd7; reg_write_in = 1'b1; alu_src = 1'b0;
    exmem_rd = 5'd5; exmem_we = 1'b1; exmem_result = 32'h11;
    memwb_rd = 5'd5; memwb_we = 1'b1; memwb_result = 32'h22;
    tick();
    chk("cap1_out_valid", {31'b0, out_valid}, 32'h1);
    chk("fwd_exmem_prio", src_a, 32'h11);
    chk("cap1_src_b", src_b, 32'h66);
    chk("cap1_store", store_data, 32'h66);
    chk("cap1_operation", {28'b0, operation}, 32'h1);
    chk("cap1_rd", {27'b0, rd_addr_out}, 32'h7);
    chk("cap1_we", {31'b0, reg_write_out}, 32'h1);

    // EX/MEM disabled: MEM/WB supplies rs1
    exmem_we = 1'b0;
    tick();
    chk("fwd_memwb", src_a, 32'h22);

    // x0 is never forwarded
    no_fwd();
    rs1_addr = 5'd0; rs1_data = 32'h0;
    exmem_rd = 5'd0; exmem_we = 1'b1; exmem_result = 32'hDEAD;
    tick();
    chk("x0_guard", src_a, 32'h0);

    // Immediate selects src_b while store_data still gets forwarded rs2
    no_fwd();
    alu_src = 1'b1; imm = 32'hFFFF_FFFC;
    rs2_addr = 5'd2; rs2_data = 32'h3;
    exmem_rd = 5'd2; exmem_we = 1'b1; exmem_result = 32'h7;
    tick();
    chk("imm_src_b", src_b, 32'hFFFF_FFFC);
    chk("imm_store", store_data, 32'h7);

    // Drain: consumer ready, nothing incoming
    no_fwd();
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", {31'b0, out_valid}, 32'h0);

    // Stall snoop: capture rs1=4 (0x40), rs2=3 (0x1), register operand B
    in_valid = 1'b1; alu_src = 1'b0; imm = 32'h0;
    rs1_addr = 5'd4; rs1_data = 32'h40; rs2_addr = 5'd3; rs2_data = 32'h1;
    alu_op = 4'h2; rd_addr_in = 5'd8; reg_write_in = 1'b1;
    tick();
    chk("stall_cap_src_b", src_b, 32'h1);
    chk("stall_cap_store", store_data, 32'h1);

    // Stall with a different instruction offered; it must not be taken
    out_ready = 1'b0;
    rs2_data = 32'hBAD; rs1_data = 32'hBAD; alu_op = 4'h6; rd_addr_in = 5'd9;
    memwb_rd = 5'd3; memwb_we = 1'b1; memwb_result = 32'h99;
    exmem_rd = 5'd4; exmem_we = 1'b1; exmem_result = 32'h44;
    #1;
    chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    chk("snoop_src_b", src_b, 32'h99);
    chk("snoop_store", store_data, 32'h99);
    chk("snoop_src_a", src_a, 32'h44);
    chk("snoop_operation", {28'b0, operation}, 32'h2);
    chk("snoop_rd", {27'b0, rd_addr_out}, 32'h8);
    chk("snoop_out_valid", {31'b0, out_valid}, 32'h1);
    chk("snoop_in_ready", {31'b0, in_ready}, 32'h0);

    // Writeback pulse ends; held values must persist
    no_fwd();
    tick();
    chk("snoop_sticky_b", src_b, 32'h99);
    chk("snoop_sticky_a", src_a, 32'h44);

    // Flush beats a simultaneous transfer
    out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
    alu_op = 4'h3; rd_addr_in = 5'd9; reg_write_in = 1'b1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_we", {31'b0, reg_write_out}, 32'h0);
    chk("flush_operation", {28'b0, operation}, 32'h0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_no_present", {31'b0, out_valid}, 32'h0);

    // Reset during a stall drops the held entry
    in_valid = 1'b1; rs1_addr = 5'd1; rs1_data = 32'h77; alu_op = 4'h4;
    tick();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    chk("pre_rst_src_a", src_a, 32'h77);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    tick();
    chk("midstall_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("midstall_rst_src_a", src_a, 32'h0);
    chk("midstall_rst_op", {28'b0, operation}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU and drives its SrcA, SrcB and Operation inputs.
- Captures decoded operands and applies EX/MEM and MEM/WB forwarding at capture time.
- While an entry is held by a downstream stall, it keeps snooping writebacks so operands never go stale.
- Valid/ready handshake on both sides; synchronous flush for branch redirect.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard held/incoming entry
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- rs1_addr, rs2_addr  in  REG_ADDR_W  source register indices
- rs1_data, rs2_data  in  DATA_WIDTH  register-file read values
- imm  in  DATA_WIDTH  sign-extended immediate
- alu_src  in  1  1: SrcB = imm, 0: SrcB = rs2
- alu_op  in  OPCODE_LENGTH  ALU operation code
- rd_addr_in, reg_write_in  in  REG_ADDR_W, 1  destination info, passed through
- exmem_rd, exmem_we, exmem_result  in  REG_ADDR_W, 1, DATA_WIDTH  EX/MEM forwarding source
- memwb_rd, memwb_we, memwb_result  in  REG_ADDR_W, 1, DATA_WIDTH  MEM/WB forwarding source
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream consumes this cycle
- src_a, src_b  out  DATA_WIDTH  ALU operands
- operation  out  OPCODE_LENGTH  ALU operation code
- store_data  out  DATA_WIDTH  forwarded rs2, for stores
- rd_addr_out, reg_write_out  out  REG_ADDR_W, 1  passed-through destination info

Behaviour:
- Reset (rst_n=0 at posedge):
  - out_valid=0.
  - src_a, src_b, store_data, rd_addr_out, reg_write_out = 0.
  - operation=4'b0000 (ADD).
  - Held rs1/rs2 indices cleared to 0.
  - Reset mid-stall drops the entry.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single entry, no skid).
  - A transfer occurs when in_valid && in_ready. Latency is 1 cycle: captured values appear on the outputs the next cycle.
  - If out_ready=1 and in_valid=0, out_valid falls to 0 next cycle.
- Forward select fwd(addr, rf):
  - If addr!=0, exmem_we and exmem_rd==addr: use exmem_result.
  - Else if addr!=0, memwb_we and memwb_rd==addr: use memwb_result.
  - Else: use rf.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Capture:
  - src_a = fwd(rs1).
  - store_data = fwd(rs2).
  - src_b = alu_src ? imm : fwd(rs2).
  - Latch rs1/rs2 indices, alu_src, alu_op, rd_addr_in and reg_write_in.
- Hold snoop (out_valid && !out_ready, no flush):
  - Each cycle, re-apply fwd() to the held indices, using the current held value as rf.
  - Update src_a and store_data; update src_b only when the held alu_src=0.
  - operation and rd fields are stable during hold.
- Flush:
  - out_valid=0 next cycle; the incoming instruction is not captured even if in_valid && in_ready.
  - Data registers may keep old values, but operation/reg_write_out go to ADD/0.
  - Flush overrides capture and snoop. Reset overrides flush.
- Stall/flush hazards: no load-use detection in this block; decode withholds in_valid.

Decomposition:
- Package alu_pkg:
  - ALU opcode constants ALU_ADD=4'b0000 through ALU_SLT=4'b1001, matching the ALU decode.
  - DATA_WIDTH, OPCODE_LENGTH and REG_ADDR_W defaults.
  - Typedef for the held entry struct.
- Sub-module fwd_mux: combinational priority select.
  - Inputs: addr, rf_val, both forward sources.
  - Instantiated twice for capture (rs1, rs2) and twice for snoop.

Test Plan:
- Reset: rst_n=0 with in_valid=1 → out_valid=0, operation=0, src_a=src_b=0. First capture occurs one cycle after rst_n=1.
- Forward priority: rs1=5; exmem_rd=5/we=1/result=0x11; memwb_rd=5/we=1/result=0x22 → src_a=0x11. With exmem_we=0 → src_a=0x22.
- x0 guard: rs1=0, exmem_rd=0, exmem_we=1, result=0xDEAD, rs1_data=0 → src_a=0.
- Immediate path: alu_src=1, imm=0xFFFFFFFC, rs2 forwarded=0x7 → src_b=0xFFFFFFFC, store_data=0x7.
- Stall snoop: capture rs2=3 with alu_src=0 and value 0x1, hold out_ready=0. Pulse memwb_rd=3/we=1/result=0x99 → src_b and store_data become 0x99 next cycle, operation unchanged, in_ready=0.
- Flush vs capture: out_valid=1, out_ready=1, in_valid=1 and flush=1 in the same cycle → out_valid=0 next cycle, reg_write_out=0, next instruction not presented.
